dram_cmd_decoder: RTL
=====================

DRAM_CMD_DECODER -- requirements
Module: dram_cmd_decoder

Interface
REQ-001 SHALL have parameters: TRCD, default 12, minimum ACTIVATE-to-READ/WRITE cycles on the same bank.
REQ-002 SHALL have parameter TRP, default 10, minimum PRECHARGE-to-ACTIVATE cycles on the same bank.
REQ-003 SHALL have ports (name direction width meaning):
- CLK  in  1  sole clock.
- nRST  in  1  asynchronous active-low reset.
- CS_n, ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14  in  1 each  DRAM command pins.
- BG  in  2  bank group.
- BA  in  2  bank.
- ADDR  in  14  address A13..A0.
- ADDR_17  in  1  address A17.
- err_clr  in  1  clears sticky error.
- cmd_valid  out  1  decoded non-NOP command, one-cycle pulse.
- cmd_type  out  3  0=ACT, 1=RD, 2=WR, 3=PRE, 4=PREA, 5=REF, 6=MRS, 7=ZQ.
- cmd_bank  out  4  {BG,BA}.
- cmd_row  out  18  row for ACT.
- cmd_col  out  10  ADDR[9:0] for RD/WR.
- cmd_ap  out  1  auto-precharge (A10) for RD/WR.
- bank_open  out  16  per-bank open flag, index {BG,BA}.
- err_state  out  1  one-cycle pulse on bank-state protocol error.
- err_timing  out  1  one-cycle pulse on tRCD/tRP violation.
- err_sticky  out  1  OR of all errors since last clear.

Function
REQ-004 SHALL sample pins every CLK rising edge; all outputs registered, latency 1 cycle from sampling edge.
REQ-005 SHALL decode {CS_n,ACT_n,RAS,CAS,WE}: 1xxxx DESEL, 00xxx ACT, 01000 MRS, 01001 REF, 01010 PRE (PREA if ADDR[10]=1), 01100 WR, 01101 RD, 01110 ZQ, 01111 NOP.
REQ-006 SHALL hold cmd_valid=0 for DESEL and NOP; all other cmd_* outputs hold last value then.
REQ-007 SHALL form ACT row as {ADDR_17,RAS_n_A16,CAS_n_A15,WE_n_A14,ADDR[13:0]}.
REQ-008 SHALL keep per bank: open flag, 18-bit open row, down-counter (tRCD after ACT, tRP after close), counter mode bit.
REQ-009 ACT to closed bank: set open, store row, load counter TRCD-1; ACT to open bank: err_state=1, state unchanged.
REQ-010 RD/WR to closed bank: err_state=1; to open bank with counter non-zero in tRCD mode: err_timing=1; command still reported.
REQ-011 RD/WR with A10=1 to open bank: clear open, load counter TRP-1 in tRP mode, same edge.
REQ-012 PRE: open bank closes and loads TRP-1; PRE to closed bank is legal no-op. PREA: applies to all 16 banks, closed banks unchanged.
REQ-013 ACT to closed bank with counter non-zero in tRP mode: err_timing=1; bank still opens.
REQ-014 REF or MRS with any bank open: err_state=1.
REQ-015 Counters saturate at 0; decrement every cycle regardless of commands.
REQ-016 err_sticky set by any error pulse; cleared by err_clr; error on same cycle as err_clr wins (stays 1).
REQ-017 Errors SHALL never block decode or state update except REQ-009 open-bank ACT.

Reset
REQ-018 nRST low SHALL immediately clear all outputs to 0, all banks closed, rows 0, counters 0.
REQ-019 Reset mid-operation SHALL discard bank state; first command after release is decoded against all-closed state.

Configuration
REQ-020 Macro DRAM_TIMING_CHECK_EN: defined -> counters and err_timing per REQ-010/013/015; undefined -> no counters built, err_timing tied 0, bank-state checks unchanged.

Verification
REQ-021 ACT BG=1 BA=2 row 0x1234, NOP x12, RD col 0x20 -> cmd_type 0,1; bank_open[6]=1; cmd_row 0x01234; no errors.
REQ-022 ACT bank 0, RD bank 0 after 5 cycles -> err_timing=1 (macro on), 0 (macro off); err_sticky=1 only with macro on.
REQ-023 RD bank 3 with no ACT -> err_state=1, err_sticky=1; err_clr pulse -> err_sticky=0.
REQ-024 Open banks 0,5,15; PREA (ADDR[10]=1) -> bank_open=0x0000, cmd_type 4; ACT bank 5 after 4 cycles -> err_timing=1.
REQ-025 WR bank 2 with A10=1 -> cmd_ap=1, bank_open[2]=0 next cycle; REF with bank 7 open -> err_state=1.
REQ-026 Assert nRST mid-sequence with banks open -> all outputs 0 asynchronously; RD after release -> err_state=1.

Source files
------------

// File: rtl/dram_cmd_decoder.sv
// dram_cmd_decoder
// Decodes DDR command pins into registered command fields. Keeps per-bank open/row
// state and flags bank-state protocol errors.
// Optional macro DRAM_TIMING_CHECK_EN: builds per-bank tRCD/tRP down-counters and
// drives err_timing. Without it, err_timing is tied low and no counters exist.
module dram_cmd_decoder #(
    parameter int TRCD = 12,
    parameter int TRP  = 10
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        CS_n,
    input  logic        ACT_n,
    input  logic        RAS_n_A16,
    input  logic        CAS_n_A15,
    input  logic        WE_n_A14,
    input  logic [1:0]  BG,
    input  logic [1:0]  BA,
    input  logic [13:0] ADDR,
    input  logic        ADDR_17,
    input  logic        err_clr,
    output logic        cmd_valid,
    output logic [2:0]  cmd_type,
    output logic [3:0]  cmd_bank,
    output logic [17:0] cmd_row,
    output logic [9:0]  cmd_col,
    output logic        cmd_ap,
    output logic [15:0] bank_open,
    output logic        err_state,
    output logic        err_timing,
    output logic        err_sticky
);

    localparam logic [2:0] CMD_ACT  = 3'd0;
    localparam logic [2:0] CMD_RD   = 3'd1;
    localparam logic [2:0] CMD_WR   = 3'd2;
    localparam logic [2:0] CMD_PRE  = 3'd3;
    localparam logic [2:0] CMD_PREA = 3'd4;
    localparam logic [2:0] CMD_REF  = 3'd5;
    localparam logic [2:0] CMD_MRS  = 3'd6;
    localparam logic [2:0] CMD_ZQ   = 3'd7;

    logic        dec_valid;
    logic [2:0]  dec_type;
    logic [3:0]  bank_sel;
    logic [17:0] act_row;
    logic        is_act, is_rdwr, is_pre, is_prea, is_refmrs;
    logic        sel_open;
    logic        act_ok;
    logic [15:0] close_vec;
    logic        state_hit;
    logic        timing_hit;
    logic [17:0] row_q [16];

    assign bank_sel = {BG, BA};
    assign act_row  = {ADDR_17, RAS_n_A16, CAS_n_A15, WE_n_A14, ADDR};

    // Pin decode; DESEL, NOP and the unused 01011 pattern produce no command
    always_comb begin
        dec_valid = 1'b0;
        dec_type  = CMD_ACT;
        if (!CS_n) begin
            if (!ACT_n) begin
                dec_valid = 1'b1;
                dec_type  = CMD_ACT;
            end else begin
                case ({RAS_n_A16, CAS_n_A15, WE_n_A14})
                    3'b000: begin dec_valid = 1'b1; dec_type = CMD_MRS; end
                    3'b001: begin dec_valid = 1'b1; dec_type = CMD_REF; end
                    3'b010: begin dec_valid = 1'b1; dec_type = ADDR[10] ? CMD_PREA : CMD_PRE; end
                    3'b100: begin dec_valid = 1'b1; dec_type = CMD_WR; end
                    3'b101: begin dec_valid = 1'b1; dec_type = CMD_RD; end
                    3'b110: begin dec_valid = 1'b1; dec_type = CMD_ZQ; end
                    default: begin dec_valid = 1'b0; dec_type = CMD_ACT; end
                endcase
            end
        end
    end

    assign is_act    = dec_valid && (dec_type == CMD_ACT);
    assign is_rdwr   = dec_valid && ((dec_type == CMD_RD) || (dec_type == CMD_WR));
    assign is_pre    = dec_valid && (dec_type == CMD_PRE);
    assign is_prea   = dec_valid && (dec_type == CMD_PREA);
    assign is_refmrs = dec_valid && ((dec_type == CMD_REF) || (dec_type == CMD_MRS));
    assign sel_open  = bank_open[bank_sel];
    // ACT to an already-open bank is the only error that leaves bank state untouched
    assign act_ok    = is_act && !sel_open;

    assign state_hit = (is_act && sel_open) || (is_rdwr && !sel_open) ||
                       (is_refmrs && (|bank_open));

    // Banks closing on this edge: PREA closes every open bank, PRE/auto-precharge one
    always_comb begin
        close_vec = 16'h0000;
        if (is_prea) begin
            close_vec = bank_open;
        end else if ((is_pre || (is_rdwr && ADDR[10])) && sel_open) begin
            close_vec[bank_sel] = 1'b1;
        end
    end

    // Per-bank open flag and open row
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bank_open <= 16'h0000;
            for (int i = 0; i < 16; i++) row_q[i] <= 18'h0;
        end else begin
            bank_open <= (bank_open & ~close_vec) | (act_ok ? (16'h0001 << bank_sel) : 16'h0000);
            if (act_ok) row_q[bank_sel] <= act_row;
        end
    end

`ifdef DRAM_TIMING_CHECK_EN
    localparam int CNT_MAX = (TRCD > TRP) ? TRCD : TRP;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] TRCD_LD = CNT_W'(TRCD - 1);
    localparam logic [CNT_W-1:0] TRP_LD  = CNT_W'(TRP - 1);

    logic [CNT_W-1:0] cnt_q [16];
    logic [15:0]      mode_trp;

    assign timing_hit = (is_rdwr && sel_open && (cnt_q[bank_sel] != '0) && !mode_trp[bank_sel]) ||
                        (act_ok && (cnt_q[bank_sel] != '0) && mode_trp[bank_sel]);

    // Per-bank timing counters: load on ACT/close, otherwise count down and hold at 0
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mode_trp <= 16'h0000;
            for (int i = 0; i < 16; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (act_ok && (bank_sel == 4'(i))) begin
                    cnt_q[i]    <= TRCD_LD;
                    mode_trp[i] <= 1'b0;
                end else if (close_vec[i]) begin
                    cnt_q[i]    <= TRP_LD;
                    mode_trp[i] <= 1'b1;
                end else if (cnt_q[i] != '0) begin
                    cnt_q[i]    <= cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

    // Timing error pulse
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) err_timing <= 1'b0;
        else       err_timing <= timing_hit;
    end
`else
    assign timing_hit = 1'b0;
    assign err_timing = 1'b0;
`endif

    // Registered command fields and error flags; fields hold when no command decodes.
    // RD/WR to an open bank reports that bank's open row on cmd_row.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cmd_valid  <= 1'b0;
            cmd_type   <= 3'd0;
            cmd_bank   <= 4'd0;
            cmd_row    <= 18'h0;
            cmd_col    <= 10'h0;
            cmd_ap     <= 1'b0;
            err_state  <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            cmd_valid  <= dec_valid;
            err_state  <= state_hit;
            err_sticky <= (err_sticky && !err_clr) || state_hit || timing_hit;
            if (dec_valid) begin
                cmd_type <= dec_type;
                cmd_bank <= bank_sel;
            end
            if (is_act) cmd_row <= act_row;
            if (is_rdwr) begin
                cmd_col <= ADDR[9:0];
                cmd_ap  <= ADDR[10];
                if (sel_open) cmd_row <= row_q[bank_sel];
            end
        end
    end

endmodule
